// File: rtl/usb_in_pkg.sv
// Shared types and default sizing for the USB IN result packer.
package usb_in_pkg;

  localparam int DEF_ADDR_W       = 9;
  localparam int DEF_LEN_W        = 10;
  localparam int DEF_MAX_LEN      = 512;
  localparam int DEF_FLUSH_CYCLES = 1024;
  localparam int DEF_SYNC_STAGES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_ACK_HI = 3'd3,
    ST_ACK_LO = 3'd4
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/usb_in_result_packer_sync_ff.sv
// Multi-stage flop synchroniser for slow level signals from the USB clock domain.
module sync_ff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/usb_in_result_packer.sv
// Packs a valid/ready/last byte stream into the USB IN endpoint buffer and
// runs the commit request/ack handshake with the USB domain.
//
// state     | meaning
// IDLE      | wait for configured and a free IN buffer
// FILL      | accept bytes, write them to the buffer, watch flush timer
// COMMIT    | hold commit request and length until ack is seen
// ACK_HI    | request dropped, wait for ack to fall
// ACK_LO    | count the packet, return to IDLE
module usb_in_result_packer
  import usb_in_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int MAX_LEN      = DEF_MAX_LEN,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              usb_configured,
  input  logic              buf_in_ready,
  input  logic              buf_in_commit_ack,
  output logic [ADDR_W-1:0] buf_in_addr,
  output logic [7:0]        buf_in_data,
  output logic              buf_in_wren,
  output logic              buf_in_commit,
  output logic [LEN_W-1:0]  buf_in_commit_len,
  output logic [15:0]       pkt_count,
  output logic [7:0]        abort_count
);

  localparam int               TMR_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [LEN_W-1:0] LP_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [TMR_W-1:0] LP_FLUSH   = TMR_W'(FLUSH_CYCLES);
  localparam logic             LP_FLUSH_EN = (FLUSH_CYCLES != 0);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [2:0]        w_sync_in;
  logic [2:0]        w_sync_out;
  logic              w_cfg_s;
  logic              w_rdy_s;
  logic              w_ack_s;

  logic [LEN_W-1:0]  r_count;
  logic [TMR_W-1:0]  r_flush_tmr;
  logic              r_wren;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic [LEN_W-1:0]  r_len;
  logic [15:0]       r_pkt_cnt;
  logic [7:0]        r_abort_cnt;

  logic              w_fill;
  logic              w_abort;
  logic              w_accept;
  logic              w_close;
  logic              w_flush;
  logic [LEN_W-1:0]  w_count_inc;

  assign w_sync_in = {usb_configured, buf_in_ready, buf_in_commit_ack};

  sync_ff #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (3)
  ) u_sync (
    .clk   (clk_50),
    .reset (reset),
    .i_d   (w_sync_in),
    .o_q   (w_sync_out)
  );

  assign {w_cfg_s, w_rdy_s, w_ack_s} = w_sync_out;

  // Losing configuration in FILL overrides any byte offered in the same cycle.
  always_comb begin
    w_fill      = (r_state == ST_FILL);
    w_count_inc = r_count + 1'b1;
    w_abort     = w_fill & ~w_cfg_s;
    w_accept    = w_fill & in_valid & ~w_abort;
    w_close     = w_accept & (in_last | (w_count_inc == LP_MAX_LEN));
    w_flush     = LP_FLUSH_EN & w_fill & ~w_accept & ~w_abort
                  & (r_count != '0) & (r_flush_tmr == TMR_W'(1));
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cfg_s && w_rdy_s) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (w_abort)                w_state_nxt = ST_IDLE;
        else if (w_close || w_flush) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (w_ack_s) w_state_nxt = ST_ACK_HI;
      end
      ST_ACK_HI: begin
        if (!w_ack_s) w_state_nxt = ST_ACK_LO;
      end
      ST_ACK_LO: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Write port, byte count and flush timer.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_count     <= '0;
      r_flush_tmr <= '0;
      r_wren      <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_len       <= '0;
    end else begin
      r_wren <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_count     <= '0;
        r_flush_tmr <= '0;
      end
      if (w_accept) begin
        r_wren      <= 1'b1;
        r_addr      <= r_count[ADDR_W-1:0];
        r_data      <= in_data;
        r_count     <= w_count_inc;
        r_flush_tmr <= LP_FLUSH;
        if (w_close) r_len <= w_count_inc;
      end else if (w_fill && (r_count != '0) && (r_flush_tmr != '0)) begin
        r_flush_tmr <= r_flush_tmr - 1'b1;
      end
      if (w_flush) r_len <= r_count;
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_pkt_cnt   <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (r_state == ST_ACK_LO) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_abort)              r_abort_cnt <= sat_inc8(r_abort_cnt);
    end
  end

  assign in_ready          = w_fill;
  assign buf_in_wren       = r_wren;
  assign buf_in_addr       = r_addr;
  assign buf_in_data       = r_data;
  assign buf_in_commit     = (r_state == ST_COMMIT);
  assign buf_in_commit_len = r_len;
  assign pkt_count         = r_pkt_cnt;
  assign abort_count       = r_abort_cnt;

endmodule

// File: tb/tb_usb_in_result_packer.sv
// Self-checking bench for usb_in_result_packer: directed scenarios with random
// valid gaps, data and ack delays, checked against a packet-level model.
module tb_usb_in_result_packer;

  localparam int ADDR_W  = 9;
  localparam int LEN_W   = 10;
  localparam int MAX_LEN = 512;
  localparam int FLUSH   = 16;
  localparam int SYNC    = 2;

  logic              clk_50 = 1'b0;
  logic              reset;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              usb_configured;
  logic              buf_in_ready;
  logic              buf_in_commit_ack;

  logic              in_ready;
  logic [ADDR_W-1:0] buf_in_addr;
  logic [7:0]        buf_in_data;
  logic              buf_in_wren;
  logic              buf_in_commit;
  logic [LEN_W-1:0]  buf_in_commit_len;
  logic [15:0]       pkt_count;
  logic [7:0]        abort_count;

  logic              nf_in_ready;
  logic [ADDR_W-1:0] nf_buf_in_addr;
  logic [7:0]        nf_buf_in_data;
  logic              nf_buf_in_wren;
  logic              nf_buf_in_commit;
  logic [LEN_W-1:0]  nf_buf_in_commit_len;
  logic [15:0]       nf_pkt_count;
  logic [7:0]        nf_abort_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int exp_pkt  = 0;

  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [7:0]        wr_data_q [$];
  logic [7:0]        exp_q     [$];
  bit                dut_commit_seen = 1'b0;
  bit                nf_commit_seen  = 1'b0;

  always #10 clk_50 = ~clk_50;

  usb_in_result_packer #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN),
    .FLUSH_CYCLES(FLUSH), .SYNC_STAGES(SYNC)
  ) u_dut (
    .clk_50(clk_50), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .usb_configured(usb_configured), .buf_in_ready(buf_in_ready),
    .buf_in_commit_ack(buf_in_commit_ack),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
    .buf_in_commit(buf_in_commit), .buf_in_commit_len(buf_in_commit_len),
    .pkt_count(pkt_count), .abort_count(abort_count)
  );

  // Same stimulus, flush disabled.
  usb_in_result_packer #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN),
    .FLUSH_CYCLES(0), .SYNC_STAGES(SYNC)
  ) u_nf (
    .clk_50(clk_50), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(nf_in_ready),
    .usb_configured(usb_configured), .buf_in_ready(buf_in_ready),
    .buf_in_commit_ack(buf_in_commit_ack),
    .buf_in_addr(nf_buf_in_addr), .buf_in_data(nf_buf_in_data), .buf_in_wren(nf_buf_in_wren),
    .buf_in_commit(nf_buf_in_commit), .buf_in_commit_len(nf_buf_in_commit_len),
    .pkt_count(nf_pkt_count), .abort_count(nf_abort_count)
  );

  always @(negedge clk_50) begin
    if (buf_in_wren) begin
      wr_addr_q.push_back(buf_in_addr);
      wr_data_q.push_back(buf_in_data);
    end
    if (buf_in_commit)    dut_commit_seen = 1'b1;
    if (nf_buf_in_commit) nf_commit_seen  = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d, expected end before limit", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_50);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_in_ready"},   in_ready, 0);
    check({pfx, "_wren"},       buf_in_wren, 0);
    check({pfx, "_commit"},     buf_in_commit, 0);
    check({pfx, "_addr"},       buf_in_addr, 0);
    check({pfx, "_data"},       buf_in_data, 0);
    check({pfx, "_len"},        buf_in_commit_len, 0);
    check({pfx, "_pkt_count"},  pkt_count, 0);
    check({pfx, "_abort_cnt"},  abort_count, 0);
  endtask

  task automatic wait_ready(input int budget, output int waited);
    waited = 0;
    while (!in_ready && waited < budget) begin
      tick();
      waited++;
    end
  endtask

  // Ack responder: ack after dly cycles, then release once the request drops.
  task automatic do_ack(input int dly);
    int g;
    bit bad_rdy;
    bit bad_hold;
    logic [LEN_W-1:0] len0;
    bad_rdy  = 1'b0;
    bad_hold = 1'b0;
    len0     = buf_in_commit_len;
    repeat (dly) begin
      tick();
      if (!buf_in_commit || buf_in_commit_len !== len0) bad_hold = 1'b1;
      if (in_ready) bad_rdy = 1'b1;
    end
    buf_in_commit_ack = 1'b1;
    g = 0;
    while (buf_in_commit && g < 40) begin
      tick();
      g++;
      if (in_ready) bad_rdy = 1'b1;
    end
    check("commit_released", buf_in_commit, 0);
    buf_in_commit_ack = 1'b0;
    exp_pkt++;
    g = 0;
    while (pkt_count != 16'(exp_pkt) && g < 40) begin
      tick();
      g++;
      if (in_ready) bad_rdy = 1'b1;
    end
    check("pkt_count", pkt_count, exp_pkt);
    check("commit_hold", bad_hold, 0);
    check("in_ready_low_handshake", bad_rdy, 0);
  endtask

  task automatic finish_pkt(input int dly);
    int bad;
    @(negedge clk_50);
    #1;
    check("commit_len", buf_in_commit_len, exp_q.size());
    check("wren_count", wr_addr_q.size(), exp_q.size());
    bad = 0;
    foreach (exp_q[i]) begin
      if (i >= wr_addr_q.size() || wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_q[i])
        bad++;
    end
    check("wr_content_errors", bad, 0);
    check("in_ready_in_commit", in_ready, 0);
    wr_addr_q.delete();
    wr_data_q.delete();
    do_ack(dly);
    exp_q.delete();
  endtask

  // Model: a packet closes on an accepted last byte or when it reaches
  // MAX_LEN; a leftover partial packet closes FLUSH+1 cycles after its last byte.
  task automatic stream(input int nbytes, input int last_at, input int last_prob,
                        input int ack_dly, input bit rnd, input logic [7:0] base);
    int  sent;
    int  idle_run;
    int  guard;
    int  g;
    bit  acc;
    bit  close;
    bit  bad;
    sent     = 0;
    idle_run = 0;
    guard    = 0;
    exp_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    while (sent < nbytes && guard < 30000) begin
      guard++;
      in_valid = (idle_run >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_data  = rnd ? 8'($urandom) : 8'(sent + int'(base));
      in_last  = (sent == last_at) || (last_prob != 0 && $urandom_range(1, last_prob) == 1);
      acc      = in_valid && in_ready;
      close    = 1'b0;
      if (acc) begin
        exp_q.push_back(in_data);
        sent++;
        acc_cyc  = cyc;
        close    = in_last || (exp_q.size() == MAX_LEN);
        idle_run = 0;
      end else begin
        idle_run++;
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("commit_on_close", buf_in_commit, close);
      if (buf_in_commit) finish_pkt(ack_dly);
      else if (close)    exp_q.delete();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (exp_q.size() != 0) begin
      g = 0;
      while (!buf_in_commit && g < FLUSH + 40) begin
        tick();
        g++;
      end
      check("flush_latency", 32'(cyc - acc_cyc), FLUSH + 1);
      if (buf_in_commit) finish_pkt(ack_dly);
      else               exp_q.delete();
    end else begin
      bad = 1'b0;
      repeat (FLUSH + 10) begin
        tick();
        if (buf_in_commit) bad = 1'b1;
      end
      check("no_extra_commit", bad, 0);
    end
    check("stream_sent", sent, nbytes);
  endtask

  initial begin
    int  n;
    int  sent;
    int  g;
    bit  bad;

    reset             = 1'b1;
    in_data           = 8'h00;
    in_valid          = 1'b0;
    in_last           = 1'b0;
    usb_configured    = 1'b0;
    buf_in_ready      = 1'b0;
    buf_in_commit_ack = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");

    // Backpressure: configured but no free buffer.
    reset          = 1'b0;
    usb_configured = 1'b1;
    in_valid       = 1'b1;
    bad            = 1'b0;
    repeat (20) begin
      in_data = 8'($urandom);
      tick();
      if (in_ready) bad = 1'b1;
    end
    check("bp_in_ready_low", bad, 0);
    check("bp_no_wren", wr_addr_q.size(), 0);
    in_valid     = 1'b0;
    buf_in_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_latency", n, SYNC + 1);

    // Single byte with last.
    stream(1, 0, 0, 5, 1'b0, 8'h05);

    // Flush of a 3-byte partial packet; the flush-disabled copy must never commit.
    nf_commit_seen = 1'b0;
    stream(3, -1, 0, 10, 1'b1, 8'h00);
    repeat (40) tick();
    check("nf_no_commit", nf_commit_seen, 0);
    check("nf_still_fill", nf_in_ready, 1);

    reset = 1'b1;
    tick();
    tick();
    reset   = 1'b0;
    exp_pkt = 0;
    wait_ready(20, n);
    check("ready_after_reset", in_ready, 1);

    // 600 bytes, no last: one full packet then a flushed 88-byte remainder.
    stream(600, -1, 0, 20, 1'b0, 8'h00);

    // last on the MAX_LEN-th byte: exactly one commit.
    stream(MAX_LEN, MAX_LEN - 1, 0, 3, 1'b1, 8'h00);

    // Random packet lengths, data and ack delay.
    stream(300, -1, 25, $urandom_range(1, 8), 1'b1, 8'h00);

    // Abort after 10 bytes.
    wait_ready(20, n);
    dut_commit_seen = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    sent     = 0;
    g        = 0;
    in_valid = 1'b1;
    while (sent < 10 && g < 100) begin
      in_data = 8'($urandom);
      if (in_ready) sent++;
      tick();
      g++;
    end
    in_valid       = 1'b0;
    usb_configured = 1'b0;
    repeat (10) tick();
    check("abort_count", abort_count, 1);
    check("abort_no_commit", dut_commit_seen, 0);
    check("abort_idle", in_ready, 0);
    check("abort_wrens", wr_addr_q.size(), 10);
    buf_in_ready   = 1'b0;
    usb_configured = 1'b1;
    bad            = 1'b0;
    repeat (8) begin
      tick();
      if (in_ready) bad = 1'b1;
    end
    check("abort_wait_both", bad, 0);
    buf_in_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("abort_reenter_latency", n, SYNC + 1);

    // Reset while in COMMIT.
    in_data  = 8'hAA;
    in_valid = 1'b1;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("pre_reset_commit", buf_in_commit, 1);
    reset = 1'b1;
    tick();
    check_reset_vals("commit_reset");
    reset = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_in_result_packer.md
Name: usb_in_result_packer

Overview:
- Downstream stage between result producers (hamming_distance and later ICBLBC engines) and the usb2_top IN endpoint buffer.
- Accepts a byte stream with valid/ready/last, writes the bytes into the IN buffer, and commits packets of up to MAX_LEN bytes.
- Runs the commit request/ack handshake with the USB domain.
- Replaces the hand-coded write/commit states in the top level so any number of result bytes can go out per request.

Parameters:
- ADDR_W, 9, IN buffer address width.
- LEN_W, 10, commit length width.
- MAX_LEN, 512, bytes per packet before an automatic commit (1..2^ADDR_W).
- FLUSH_CYCLES, 1024, idle clk_50 cycles with a partial packet before a forced commit; 0 disables the flush.
- SYNC_STAGES, 2, synchroniser depth for USB-domain inputs.

Ports:
- clk_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- in_data  in  8  result byte.
- in_valid  in  1  in_data is valid.
- in_last  in  1  byte closes the packet.
- in_ready  out  1  block accepts a byte this cycle.
- usb_configured  in  1  async; synchronised internally.
- buf_in_ready  in  1  async; synchronised internally.
- buf_in_commit_ack  in  1  async; synchronised internally.
- buf_in_addr  out  ADDR_W  write address.
- buf_in_data  out  8  write data.
- buf_in_wren  out  1  write strobe, one cycle per byte.
- buf_in_commit  out  1  commit request, level.
- buf_in_commit_len  out  LEN_W  packet length.
- pkt_count  out  16  packets committed, wraps.
- abort_count  out  8  packets abandoned, saturates at 255.

Behaviour:
- Reset: FSM to IDLE. in_ready=0, buf_in_wren=0, buf_in_commit=0, buf_in_addr=0, buf_in_data=0, buf_in_commit_len=0, counters=0, byte count=0, flush timer=0, synchroniser flops=0.
- Synchronised signals are suffixed _s. They lag the raw inputs by SYNC_STAGES cycles.
- States are IDLE, FILL, COMMIT, ACK_HI, ACK_LO.
- IDLE:
  - in_ready=0.
  - Go to FILL when configured_s & buf_in_ready_s; clear byte count.
- FILL:
  - in_ready=1 (combinational from state).
  - An accepted byte (in_valid & in_ready) is registered: next cycle buf_in_wren=1, buf_in_addr=count, buf_in_data=in_data. Write latency is 1 cycle.
  - Count increments per accepted byte.
  - Each accept reloads the flush timer.
- Commit triggers, evaluated on the accept cycle:
  - in_last accepted, or count+1 == MAX_LEN: next state COMMIT, buf_in_commit_len=count+1.
  - in_ready drops in the same cycle, so no byte is accepted while leaving FILL.
- Flush:
  - Applies when count>0, FLUSH_CYCLES≠0, and there is no accept for FLUSH_CYCLES consecutive cycles.
  - Then go to COMMIT with len=count.
  - With count=0 the flush timer is held at 0.
- COMMIT:
  - Entered after the final wren cycle.
  - Hold buf_in_commit=1 and a stable len until commit_ack_s=1, then go to ACK_HI.
- ACK_HI:
  - buf_in_commit=0.
  - Wait for commit_ack_s=0, then go to ACK_LO.
- ACK_LO:
  - pkt_count+1, then go to IDLE.
  - IDLE re-checks buf_in_ready_s, so a back-to-back stream stalls until the USB side frees the buffer.
- Abort:
  - configured_s falling in FILL: discard the packet, no commit, abort_count+1 (saturating), go to IDLE.
  - In COMMIT/ACK_HI the handshake completes regardless.
- Simultaneous accept + flush expiry: the accept wins and the timer reloads.
- Simultaneous in_last and MAX_LEN boundary: a single commit of MAX_LEN.
- Reset mid-operation (any state): buf_in_commit=0 the next cycle and partial data is abandoned; abort_count is not incremented because it is reset.
- Width rules:
  - Count is LEN_W bits and never exceeds MAX_LEN.
  - buf_in_addr = count[ADDR_W-1:0].
  - Zero-length commits are impossible.

Decomposition:
- Package usb_in_pkg: state encoding localparams (IDLE=0, FILL=1, COMMIT=2, ACK_HI=3, ACK_LO=4), default widths, MAX_LEN and FLUSH_CYCLES defaults.
- Sub-module sync_ff (param STAGES, WIDTH) handles the three USB-domain inputs; it is reusable elsewhere in the top level.

Test Plan:
- Single byte: configured, buf_in_ready=1, send 0x05 with last.
  - Required: exactly one wren, addr 0, data 0x05.
  - Required: commit=1 with len=1, held until the ack is raised.
  - Required: ack raised then dropped gives pkt_count=1 and a return to IDLE.
- Full packet: stream 600 bytes (0x00..0xFF repeating), no last, ack responder 20 cycles.
  - Required: first commit len 512, addresses 0..511.
  - Required: in_ready=0 from commit until the next FILL.
  - Required: second packet addresses 0..87, then flush after 1024 idle cycles with len 88.
- Flush: 3 bytes then idle, FLUSH_CYCLES=16.
  - Required: commit asserted exactly 17 cycles after the last accept (flush timer expiry + 1), len=3.
  - Required: with FLUSH_CYCLES=0, no commit ever.
- Backpressure: buf_in_ready=0.
  - Required: in_ready stays 0 and no wren.
  - Raise buf_in_ready: in_ready=1 exactly SYNC_STAGES+1 cycles later.
- Abort: drop usb_configured after 10 bytes in FILL.
  - Required: no commit, abort_count=1.
  - Required: FSM returns to IDLE and re-enters FILL only after configured and buf_in_ready are both seen again.
- Reset: assert reset while in COMMIT.
  - Required: buf_in_commit=0 the next cycle, all outputs at reset values, pkt_count=0.
